can_rx_deframer: RTL and testbench

//  Receive-side stage downstream of the custom CAN node bus interface: takes sampled bus bits,

---
 rtl/can_rx_deframer_if.sv | 23 ++
 rtl/can_rx_deframer.sv | 154 +++++++++++++++
 tb/tb_can_rx_deframer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/can_rx_deframer_if.sv
// can_rx_deframer_if: sampled-bit input and parallel frame output bundle of the CAN receive deframer
interface can_rx_if;
    logic        bit_valid;
    logic        bit_in;
    logic        busy;
    logic        frame_valid;
    logic [10:0] rx_id;
    logic [3:0]  rx_dlc;
    logic [63:0] rx_data;
    logic [14:0] rx_crc;
    logic [3:0]  rx_src;
    logic        stuff_err;
    logic        form_err;
    logic        crc_err;
    modport master (
        output bit_valid, bit_in,
        input  busy, frame_valid, rx_id, rx_dlc, rx_data, rx_crc, rx_src, stuff_err, form_err, crc_err
    );
    modport slave (
        input  bit_valid, bit_in,
        output busy, frame_valid, rx_id, rx_dlc, rx_data, rx_crc, rx_src, stuff_err, form_err, crc_err
    );
endinterface

// File: rtl/can_rx_deframer.sv
// can_rx_deframer: destuffs sampled CAN bits and parses one frame into parallel fields; CRC check under CAN_RX_CRC_CHECK_EN
module can_rx_deframer #(
    parameter int IDLE_BITS = 11,
    parameter int STUFF_LEN = 5,
    parameter int MAX_BYTES = 8
) (
    input logic     sys_clk,
    input logic     reset,
    can_rx_if.slave bus
);
    localparam int IW = $clog2(IDLE_BITS + 1);
    localparam int RW = $clog2(STUFF_LEN + 1);
    typedef enum logic [3:0] {WAIT_IDLE, IDLE, ID, CTRL, DLC, DATA, CRC, TRAIL, SRC, EOF} state_t;
    state_t        state, state_nxt;
    logic [IW-1:0] idle_cnt;
    logic [RW-1:0] run_cnt;
    logic          run_val;
    logic [6:0]    bit_cnt, data_len, field_len;
    logic [10:0]   id_sh;
    logic [3:0]    dlc_sh, src_sh, dlc_val, dlc_cap;
    logic [63:0]   data_sh;
    logic [14:0]   crc_sh;
    logic          in_frame, stuffed, stuff_bit, take, last, s_err, f_err, done, crc_fail;
    assign in_frame  = !(state inside {WAIT_IDLE, IDLE});
    assign stuffed   = state inside {ID, CTRL, DLC, DATA};
    assign stuff_bit = stuffed && run_cnt == RW'(STUFF_LEN);
    assign take      = bus.bit_valid && !stuff_bit;
    assign dlc_val   = {dlc_sh[2:0], bus.bit_in};
    assign dlc_cap   = dlc_val > 4'(MAX_BYTES) ? 4'(MAX_BYTES) : dlc_val;
    assign field_len = state == ID ? 7'd11 : state == CTRL ? 7'd2 : state == DLC || state == SRC ? 7'd4 :
                       state == DATA ? data_len : state == CRC ? 7'd15 : state == TRAIL ? 7'd3 : 7'd7;
    assign last      = bit_cnt == field_len - 7'd1;
    assign bus.busy  = in_frame;
`ifdef CAN_RX_CRC_CHECK_EN
    logic [14:0] crc_calc;
    logic        crc_bad;
    // CRC-15 over destuffed SOF..data; SOF is dominant so restarting from zero on it covers that bit
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            crc_calc <= '0;
            crc_bad  <= 1'b0;
        end else if (bus.bit_valid && state == IDLE) begin
            crc_calc <= '0;
            crc_bad  <= 1'b0;
        end else if (take && stuffed) begin
            crc_calc <= {crc_calc[13:0], 1'b0} ^ ((bus.bit_in ^ crc_calc[14]) ? 15'h4599 : 15'h0000);
        end else if (take && state == CRC && last) begin
            crc_bad <= {crc_sh[13:0], bus.bit_in} != crc_calc;
        end
    end
    assign crc_fail = crc_bad;
`else
    assign crc_fail = 1'b0;
`endif
    // state register
    always_ff @(posedge sys_clk) state <= reset ? WAIT_IDLE : state_nxt;
    // next state plus error/completion decode for the bit being strobed
    always_comb begin
        state_nxt = state;
        s_err     = 1'b0;
        f_err     = 1'b0;
        done      = 1'b0;
        if (bus.bit_valid && stuff_bit) begin
            s_err     = bus.bit_in == run_val;
            state_nxt = s_err ? WAIT_IDLE : state;
        end else if (bus.bit_valid) begin
            case (state)
                WAIT_IDLE: state_nxt = bus.bit_in && idle_cnt == IW'(IDLE_BITS - 1) ? IDLE : WAIT_IDLE;
                IDLE:      state_nxt = bus.bit_in ? IDLE : ID;
                ID:        state_nxt = last ? CTRL : ID;
                CTRL: begin
                    f_err     = bus.bit_in;
                    state_nxt = f_err ? WAIT_IDLE : last ? DLC : CTRL;
                end
                DLC:       state_nxt = !last ? DLC : dlc_val == 4'd0 ? CRC : DATA;
                DATA:      state_nxt = last ? CRC : DATA;
                CRC:       state_nxt = last ? TRAIL : CRC;
                TRAIL: begin
                    f_err     = !bus.bit_in && bit_cnt != 7'd1;
                    state_nxt = f_err ? WAIT_IDLE : last ? SRC : TRAIL;
                end
                SRC:       state_nxt = last ? EOF : SRC;
                EOF: begin
                    f_err     = !bus.bit_in;
                    done      = bus.bit_in && last;
                    state_nxt = f_err || (done && crc_fail) ? WAIT_IDLE : done ? IDLE : EOF;
                end
                default:   state_nxt = WAIT_IDLE;
            endcase
        end
    end
    // idle/run/field counters, field shift registers and registered frame outputs
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            idle_cnt        <= '0;
            run_cnt         <= '0;
            run_val         <= 1'b1;
            bit_cnt         <= '0;
            data_len        <= '0;
            id_sh           <= '0;
            dlc_sh          <= '0;
            src_sh          <= '0;
            data_sh         <= '0;
            crc_sh          <= '0;
            bus.frame_valid <= 1'b0;
            bus.stuff_err   <= 1'b0;
            bus.form_err    <= 1'b0;
            bus.crc_err     <= 1'b0;
            bus.rx_id       <= '0;
            bus.rx_dlc      <= '0;
            bus.rx_data     <= '0;
            bus.rx_crc      <= '0;
            bus.rx_src      <= '0;
        end else begin
            bus.frame_valid <= done && !crc_fail;
            bus.crc_err     <= done && crc_fail;
            bus.stuff_err   <= s_err;
            bus.form_err    <= f_err;
            if (done && !crc_fail) begin
                bus.rx_id   <= id_sh;
                bus.rx_dlc  <= dlc_sh;
                bus.rx_data <= data_sh;
                bus.rx_crc  <= crc_sh;
                bus.rx_src  <= src_sh;
            end
            if (state != WAIT_IDLE) idle_cnt <= '0;
            else if (bus.bit_valid) idle_cnt <= bus.bit_in ? idle_cnt + 1'b1 : '0;
            if (bus.bit_valid && state == IDLE && !bus.bit_in) begin
                run_val <= 1'b0;
                run_cnt <= RW'(1);
                bit_cnt <= '0;
                data_sh <= '0;
            end
            if (bus.bit_valid && stuffed) begin
                run_cnt <= !stuff_bit && bus.bit_in == run_val ? run_cnt + 1'b1 : RW'(1);
                run_val <= bus.bit_in;
            end
            if (take && in_frame) begin
                bit_cnt <= last ? '0 : bit_cnt + 7'd1;
                case (state)
                    ID:      id_sh <= {id_sh[9:0], bus.bit_in};
                    DLC: begin
                        dlc_sh   <= dlc_val;
                        data_len <= {dlc_cap, 3'b000};
                    end
                    DATA:    data_sh[6'(7'd63 - bit_cnt)] <= bus.bit_in;
                    CRC:     crc_sh <= {crc_sh[13:0], bus.bit_in};
                    SRC:     src_sh <= {src_sh[2:0], bus.bit_in};
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_can_rx_deframer.sv
// tb_can_rx_deframer: scoreboard bench for can_rx_deframer; CRC cases compile in with CAN_RX_CRC_CHECK_EN
module tb_can_rx_deframer;
    logic sys_clk = 1'b0;
    logic reset;
    can_rx_if bus ();
    can_rx_deframer dut (.sys_clk(sys_clk), .reset(reset), .bus(bus));
    always #5 sys_clk = ~sys_clk;
    localparam logic [3:0] K_OK = 4'b0001, K_STUFF = 4'b0010, K_FORM = 4'b0100, K_CRC = 4'b1000;
    typedef struct {
        logic [3:0]  kind;
        int          at;
        logic [10:0] id;
        logic [3:0]  dlc;
        logic [63:0] data;
        logic [14:0] crc;
        logic [3:0]  src;
    } exp_t;
    exp_t sb[$];
    exp_t prev, m, e;
    bit   stream[$];
    int   n_chk = 0, n_pass = 0, n_sent = 0, n_strobe = 0, gap_max = 0, pos;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [14:0] crc_step(logic [14:0] c, bit b);
        return (b ^ c[14]) ? ({c[13:0], 1'b0} ^ 15'h4599) : {c[13:0], 1'b0};
    endfunction

    task automatic send_bit(bit b);
        int g;
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        n_sent++;
        @(posedge sys_clk);
        #1;
        bus.bit_valid = 1'b0;
        g = gap_max > 0 ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (g) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic idle(int n);
        repeat (n) send_bit(1'b1);
    endtask

    // builds the stuffed bit stream, the strobe index of the expected pulse and the expected outcome
    task automatic build_frame(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data,
                               input logic [14:0] crc, input logic [3:0] src, input logic [1:0] ctrl,
                               input logic [2:0] trail, input int eof_bad, input bit crc_flip,
                               output exp_t x, output int p);
        bit d[$];
        int nb, run;
        bit lastb;
        logic [14:0] c, crc_tx;
        stream.delete();
        p = 0;
        d.push_back(1'b0);
        for (int i = 10; i >= 0; i--) d.push_back(id[i]);
        for (int i = 1; i >= 0; i--) d.push_back(ctrl[i]);
        for (int i = 3; i >= 0; i--) d.push_back(dlc[i]);
        nb = (dlc > 4'd8 ? 8 : int'(dlc)) * 8;
        for (int i = 0; i < nb; i++) d.push_back(data[63 - i]);
        c = '0;
        run = 0;
        lastb = 1'b1;
        foreach (d[i]) begin
            c = crc_step(c, d[i]);
            if (run == 5) begin
                stream.push_back(!lastb);
                lastb = !lastb;
                run = 1;
            end
            run = (d[i] == lastb) ? run + 1 : 1;
            lastb = d[i];
            stream.push_back(d[i]);
            if ((i == 12 || i == 13) && d[i] && p == 0) p = stream.size();
        end
`ifdef CAN_RX_CRC_CHECK_EN
        crc_tx = c ^ (crc_flip ? 15'h0100 : 15'h0000);
`else
        crc_tx = crc;
`endif
        for (int i = 14; i >= 0; i--) stream.push_back(crc_tx[i]);
        for (int i = 2; i >= 0; i--) begin
            stream.push_back(trail[i]);
            if (i != 1 && !trail[i] && p == 0) p = stream.size();
        end
        for (int i = 3; i >= 0; i--) stream.push_back(src[i]);
        for (int i = 0; i < 7; i++) begin
            stream.push_back(i != eof_bad);
            if (i == eof_bad && p == 0) p = stream.size();
        end
        x = prev;
        x.kind = p != 0 ? K_FORM : crc_flip ? K_CRC : K_OK;
        if (p == 0) p = stream.size();
        if (x.kind == K_OK) begin
            x.id   = id;
            x.dlc  = dlc;
            x.data = nb == 0 ? 64'h0 : data & (~64'h0 << (64 - nb));
            x.crc  = crc_tx;
            x.src  = src;
        end
    endtask

    task automatic send_frame(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data,
                              input logic [14:0] crc, input logic [3:0] src, input logic [1:0] ctrl,
                              input logic [2:0] trail, input int eof_bad, input bit crc_flip);
        exp_t x;
        int p;
        idle(11);
        build_frame(id, dlc, data, crc, src, ctrl, trail, eof_bad, crc_flip, x, p);
        if (x.kind == K_OK) prev = x;
        x.at = n_sent + p;
        sb.push_back(x);
        for (int i = 0; i < p; i++) send_bit(stream[i]);
    endtask

    // strobes as the DUT samples them, for pulse latency
    always @(posedge sys_clk) if (bus.bit_valid) n_strobe <= n_strobe + 1;

    // scoreboard: every result pulse pops and checks one expected outcome
    always @(negedge sys_clk) begin
        if (!reset && (bus.frame_valid || bus.stuff_err || bus.form_err || bus.crc_err)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 64'({bus.crc_err, bus.form_err, bus.stuff_err, bus.frame_valid}), 64'd0);
            end else begin
                m = sb.pop_front();
                check("kind", 64'({bus.crc_err, bus.form_err, bus.stuff_err, bus.frame_valid}), 64'(m.kind));
                check("latency", 64'(n_strobe), 64'(m.at));
                check("busy_end", 64'(bus.busy), 64'd0);
                check("rx_id", 64'(bus.rx_id), 64'(m.id));
                check("rx_dlc", 64'(bus.rx_dlc), 64'(m.dlc));
                check("rx_data", bus.rx_data, m.data);
                check("rx_crc", 64'(bus.rx_crc), 64'(m.crc));
                check("rx_src", 64'(bus.rx_src), 64'(m.src));
            end
        end
    end

    initial begin
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b1;
        reset         = 1'b1;
        prev          = '{default: '0};
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_pulses", 64'({bus.crc_err, bus.form_err, bus.stuff_err, bus.frame_valid}), 64'd0);
        check("rst_id", 64'(bus.rx_id), 64'd0);
        check("rst_data", bus.rx_data, 64'd0);
        reset = 1'b0;
        send_frame(11'h7F8, 4'd1, 64'h8900_0000_0000_0000, 15'h0000, 4'h0, 2'b00, 3'b101, -1, 1'b0);
        send_frame(11'h7FF, 4'd0, 64'hDEAD_BEEF_0000_0000, 15'h0000, 4'h1, 2'b00, 3'b101, -1, 1'b0);
        idle(11);
        e = prev;
        e.kind = K_STUFF;
        e.at = n_sent + 6;
        sb.push_back(e);
        repeat (6) send_bit(1'b0);
        idle(4);
        send_bit(1'b0);
        check("no_early_sof", 64'(bus.busy), 64'd0);
        send_frame(11'h123, 4'd2, 64'hA55A_0000_0000_0000, 15'h1234, 4'h7, 2'b00, 3'b101, -1, 1'b0);
        send_frame(11'h456, 4'd3, 64'h1122_3344_5566_7788, 15'h0000, 4'h3, 2'b00, 3'b101, 3, 1'b0);
        send_frame(11'h456, 4'd3, 64'h1122_3344_5566_7788, 15'h0000, 4'h3, 2'b00, 3'b101, -1, 1'b0);
        send_frame(11'h0F0, 4'd1, 64'h3C00_0000_0000_0000, 15'h0000, 4'h2, 2'b01, 3'b101, -1, 1'b0);
        send_frame(11'h0F0, 4'd1, 64'h3C00_0000_0000_0000, 15'h0000, 4'h2, 2'b00, 3'b001, -1, 1'b0);
        send_frame(11'h321, 4'd1, 64'h5A00_0000_0000_0000, 15'h0000, 4'h9, 2'b00, 3'b111, -1, 1'b0);
        send_frame(11'h555, 4'hF, 64'h0102_0304_0506_0708, 15'h7ABC, 4'hA, 2'b00, 3'b101, -1, 1'b0);
        gap_max = 7;
        send_frame(11'h555, 4'hF, 64'h0102_0304_0506_0708, 15'h7ABC, 4'hA, 2'b00, 3'b101, -1, 1'b0);
        gap_max = 0;
        idle(11);
        build_frame(11'h2AA, 4'd2, 64'hF0F0_0000_0000_0000, 15'h0000, 4'h5, 2'b00, 3'b101, -1, 1'b0, e, pos);
        for (int i = 0; i < 22; i++) send_bit(stream[i]);
        check("mid_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(posedge sys_clk);
        #1;
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_id", 64'(bus.rx_id), 64'd0);
        check("mid_rst_data", bus.rx_data, 64'd0);
        check("mid_rst_src", 64'(bus.rx_src), 64'd0);
        reset = 1'b0;
        prev = '{default: '0};
`ifdef CAN_RX_CRC_CHECK_EN
        send_frame(11'h1A5, 4'd2, 64'hC3E1_0000_0000_0000, 15'h0000, 4'h6, 2'b00, 3'b101, -1, 1'b0);
        send_frame(11'h1A5, 4'd2, 64'hC3E1_0000_0000_0000, 15'h0000, 4'h6, 2'b00, 3'b101, -1, 1'b1);
`endif
        send_frame(11'h001, 4'd1, 64'h7E00_0000_0000_0000, 15'h0000, 4'hF, 2'b00, 3'b101, -1, 1'b0);
        repeat (20) @(posedge sys_clk);
        #1;
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
